spmv_x_fetch: RTL and testbench



---
 rtl/spmv_x_fetch.sv | 152 +++++++++++++++
 tb/tb_spmv_x_fetch.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_x_fetch.sv
// Dense-vector gather for SpMV: turns column indices into single-beat AXI reads of x,
// returning x values in order with their tags; a one-entry cache skips repeated columns.
module spmv_x_fetch #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 48,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int COL_WIDTH          = 32,
  parameter int TAG_WIDTH          = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                          cfg_flush,
  input  logic                          col_valid,
  output logic                          col_ready,
  input  logic [COL_WIDTH-1:0]          col_idx,
  input  logic [TAG_WIDTH-1:0]          col_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] out_xval,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic                          m_axi_rlast,
  output logic [31:0]                   stat_rd_cnt,
  output logic [31:0]                   stat_reuse_cnt,
  output logic [1:0]                    dbg_state
);

  localparam int SIZE_LOG2 = $clog2(C_M_AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                          cache_valid;
  logic [COL_WIDTH-1:0]          cache_col;
  logic [C_M_AXI_DATA_WIDTH-1:0] cache_val;
  logic [COL_WIDTH-1:0]          col_q;
  logic [TAG_WIDTH-1:0]          tag_q;
  logic                          lookup_hit;
  logic                          take_hit;
  logic                          take_miss;
  logic                          r_fire;
  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr;
  logic                          unused_rlast;

  // Every read is a single beat, so rlast carries no information.
  assign unused_rlast = m_axi_rlast;

  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;
  assign dbg_state     = state;

  assign rd_addr    = cfg_base_addr + (C_M_AXI_ADDR_WIDTH'(col_idx) << SIZE_LOG2);
  assign lookup_hit = cache_valid && (col_idx == cache_col) && !cfg_flush;
  assign r_fire     = (state == S_R) && m_axi_rvalid;

  // All handshakes transfer on a rising edge where valid && ready; a valid side holds its
  // payload stable until then. col_ready never depends on col_valid.
  always_comb begin
    state_nxt = state;
    col_ready = 1'b0;
    take_hit  = 1'b0;
    take_miss = 1'b0;
    case (state)
      S_IDLE: begin
        col_ready = !out_valid || out_ready;
        if (col_valid && col_ready) begin
          take_hit  = lookup_hit;
          take_miss = !lookup_hit;
          if (!lookup_hit) state_nxt = S_AR;
        end
      end
      S_AR:    if (m_axi_arready) state_nxt = S_R;
      S_R:     if (m_axi_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state         <= state_nxt;
      m_axi_arvalid <= (state_nxt == S_AR);
      m_axi_rready  <= (state_nxt == S_R);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axi_araddr   <= '0;
      tag_q          <= '0;
      col_q          <= '0;
      out_valid      <= 1'b0;
      out_xval       <= '0;
      out_tag        <= '0;
      cache_valid    <= 1'b0;
      cache_col      <= '0;
      cache_val      <= '0;
      stat_rd_cnt    <= '0;
      stat_reuse_cnt <= '0;
    end else begin
      if (take_miss) begin
        m_axi_araddr <= rd_addr;
        tag_q        <= col_tag;
        col_q        <= col_idx;
        stat_rd_cnt  <= stat_rd_cnt + 32'd1;
      end
      if (take_hit) stat_reuse_cnt <= stat_reuse_cnt + 32'd1;

      if (take_hit) begin
        out_valid <= 1'b1;
        out_xval  <= cache_val;
        out_tag   <= col_tag;
      end else if (r_fire) begin
        out_valid <= 1'b1;
        out_xval  <= m_axi_rdata;
        out_tag   <= tag_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A fill landing in the same cycle as a flush leaves the new entry valid.
      if (r_fire) begin
        cache_valid <= 1'b1;
        cache_col   <= col_q;
        cache_val   <= m_axi_rdata;
      end else if (cfg_flush) begin
        cache_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spmv_x_fetch.sv
// Bench for spmv_x_fetch: reactive AXI read slave, output monitor and a reference
// cache model feeding expected address and result queues.
module tb_spmv_x_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [47:0] cfg_base_addr;
  logic        cfg_flush;
  logic        col_valid;
  logic        col_ready;
  logic [31:0] col_idx;
  logic [31:0] col_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_xval;
  logic [31:0] out_tag;
  logic [0:0]  m_axi_arid;
  logic [47:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        m_axi_rlast;
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_reuse_cnt;
  logic [1:0]  dbg_state;

  spmv_x_fetch dut (
    .clk(clk), .rstn(rstn), .cfg_base_addr(cfg_base_addr), .cfg_flush(cfg_flush),
    .col_valid(col_valid), .col_ready(col_ready), .col_idx(col_idx), .col_tag(col_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_xval(out_xval), .out_tag(out_tag),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rlast(m_axi_rlast), .stat_rd_cnt(stat_rd_cnt), .stat_reuse_cnt(stat_reuse_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ar_delay = 0;
  int r_delay = 0;
  logic        bp_done;

  logic [63:0] exp_q[$];
  logic [47:0] exp_addr_q[$];
  int          out_cyc_q[$];

  logic        m_cv = 1'b0;
  logic [31:0] m_col = '0;
  int          m_rd = 0;
  int          m_reuse = 0;

  function automatic logic [31:0] mem_fn(input logic [47:0] a);
    if (a == 48'h1014) return 32'hDEADBEEF;
    return (a[31:0] * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // ---------------- slave and monitor ----------------
  task automatic slave_loop();
    int s = 0;
    int cnt = 0;
    logic [47:0] a = '0;
    logic [47:0] ea;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        s = 0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
      end else begin
        if (s == 4) begin m_axi_rvalid = 1'b0; s = 0; end
        if (s == 2) begin m_axi_arready = 1'b0; cnt = r_delay; s = 3; end
        if (s == 0 && m_axi_arvalid) begin
          s = 1; cnt = ar_delay; a = m_axi_araddr;
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++; $display("FAIL unexpected_ar addr=%h (no AR expected)", a);
          end else begin
            ea = exp_addr_q.pop_front();
            if (a !== ea) begin errors++; $display("FAIL ar_addr got=%h exp=%h", a, ea); end
          end
          checks++;
          if (m_axi_arlen !== 8'd0 || m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01 ||
              m_axi_arid !== 1'b0) begin
            errors++;
            $display("FAIL ar_fields got len=%0d size=%0d burst=%0d id=%0d exp 0/2/1/0",
                     m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid);
          end
        end else if (s == 1) begin
          checks++;
          if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== a) begin
            errors++;
            $display("FAIL ar_hold got valid=%b addr=%h exp 1/%h", m_axi_arvalid, m_axi_araddr, a);
          end
        end
        if (s == 1) begin
          if (cnt == 0) begin m_axi_arready = 1'b1; s = 2; end else cnt--;
        end
        if (s == 3) begin
          if (cnt == 0) begin m_axi_rvalid = 1'b1; m_axi_rdata = mem_fn(a); s = 4; end
          else cnt--;
        end
      end
      #1;
      if (rstn) begin
        checks++;
        if (m_axi_rready !== ((s == 3) || (s == 4))) begin
          errors++;
          $display("FAIL rready_window got=%b exp=%b", m_axi_rready, (s == 3) || (s == 4));
        end
      end
    end
  endtask

  task automatic mon_loop();
    logic        hold = 1'b0;
    logic [31:0] px = '0;
    logic [31:0] pt = '0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rstn) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          checks++;
          if (out_valid !== 1'b1 || out_xval !== px || out_tag !== pt) begin
            errors++;
            $display("FAIL out_hold got v=%b x=%h t=%h exp 1/%h/%h", out_valid, out_xval, out_tag, px, pt);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          out_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_out x=%h t=%h", out_xval, out_tag);
          end else begin
            e = exp_q.pop_front();
            if ({out_tag, out_xval} !== e) begin
              errors++;
              $display("FAIL out_data got t=%h x=%h exp t=%h x=%h", out_tag, out_xval, e[63:32], e[31:0]);
            end
          end
        end
        hold = out_valid && !out_ready;
        px = out_xval;
        pt = out_tag;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] col, input logic [31:0] tag);
    int n = 0;
    logic [47:0] addr;
    col_valid = 1'b1; col_idx = col; col_tag = tag;
    #1;
    while (!col_ready) begin
      @(negedge clk); #1; n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL accept_timeout col=%0d got no col_ready exp ready", col);
        @(negedge clk);
        col_valid = 1'b0;
        return;
      end
    end
    addr = cfg_base_addr + ({16'd0, col} << 2);
    if (m_cv && col == m_col && !cfg_flush) begin
      m_reuse++;
    end else begin
      exp_addr_q.push_back(addr);
      m_rd++; m_cv = 1'b1; m_col = col;
    end
    exp_q.push_back({tag, mem_fn(addr)});
    @(negedge clk);
    col_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      @(negedge clk); n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL drain_timeout got %0d results pending exp 0", exp_q.size());
        exp_q.delete(); exp_addr_q.delete();
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_flush();
    cfg_flush = 1'b1;
    @(negedge clk);
    cfg_flush = 1'b0;
    m_cv = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl got ov=%b arv=%b rr=%b st=%0d exp 0/0/0/0",
               out_valid, m_axi_arvalid, m_axi_rready, dbg_state);
    end
    checks++;
    if (out_xval !== 32'd0 || out_tag !== 32'd0 || m_axi_araddr !== 48'd0 ||
        stat_rd_cnt !== 32'd0 || stat_reuse_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got x=%h t=%h a=%h rd=%0d ru=%0d exp all 0",
               out_xval, out_tag, m_axi_araddr, stat_rd_cnt, stat_reuse_cnt);
    end
    checks++;
    if (col_ready !== 1'b1) begin errors++; $display("FAIL reset_col_ready got=%b exp=1", col_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_miss();
    int lat = 1;
    ar_delay = 0; r_delay = 2;
    send(32'd5, 32'hA5A5_0005);
    while (1) begin
      #1;
      if (out_valid || lat > 40) break;
      @(negedge clk); lat++;
    end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL miss_latency got=%0d exp=5", lat); end
    checks++;
    if (out_xval !== 32'hDEADBEEF || out_tag !== 32'hA5A5_0005) begin
      errors++;
      $display("FAIL miss_result got x=%h t=%h exp DEADBEEF/A5A50005", out_xval, out_tag);
    end
    @(negedge clk);
    drain();
    checks++;
    if (stat_rd_cnt !== 32'd1) begin errors++; $display("FAIL miss_rd_cnt got=%0d exp=1", stat_rd_cnt); end
  endtask

  task automatic test_repeat_hit();
    r_delay = 1;
    out_cyc_q.delete();
    send(32'd7, 32'h70); send(32'd7, 32'h71); send(32'd7, 32'h72);
    drain();
    checks++;
    if (stat_rd_cnt !== 32'(m_rd) || m_rd != 2) begin
      errors++; $display("FAIL hit_rd_cnt got=%0d exp=2", stat_rd_cnt);
    end
    checks++;
    if (stat_reuse_cnt !== 32'd2) begin errors++; $display("FAIL hit_reuse_cnt got=%0d exp=2", stat_reuse_cnt); end
    checks++;
    if (out_cyc_q.size() != 3 || out_cyc_q[2] - out_cyc_q[1] != 1) begin
      errors++; $display("FAIL hit_back_to_back got %0d results, not consecutive exp 3 consecutive", out_cyc_q.size());
    end
  endtask

  task automatic test_flush();
    int rd0 = int'(stat_rd_cnt);
    int ru0 = int'(stat_reuse_cnt);
    pulse_flush();
    send(32'd7, 32'h80);
    drain();
    cfg_flush = 1'b1;
    send(32'd7, 32'h81);
    cfg_flush = 1'b0;
    drain();
    checks++;
    if (int'(stat_rd_cnt) - rd0 != 2) begin
      errors++; $display("FAIL flush_rd got=%0d exp=2", int'(stat_rd_cnt) - rd0);
    end
    checks++;
    if (stat_reuse_cnt !== 32'(ru0)) begin
      errors++; $display("FAIL flush_reuse got=%0d exp=%0d", stat_reuse_cnt, ru0);
    end
    send(32'd7, 32'h82);
    drain();
    checks++;
    if (stat_reuse_cnt !== 32'(ru0 + 1) || stat_rd_cnt !== 32'(rd0 + 2)) begin
      errors++; $display("FAIL refill_hit got ru=%0d rd=%0d exp %0d/%0d", stat_reuse_cnt, stat_rd_cnt, ru0 + 1, rd0 + 2);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    r_delay = 0;
    bp_done = 1'b0;
    out_ready = 1'b0;
    fork
      begin send(32'd3, 32'h30); send(32'd4, 32'h40); bp_done = 1'b1; end
    join_none
    while (1) begin
      @(negedge clk); #1; n++;
      if (out_valid || n > 50) break;
    end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL bp_first_result got out_valid=0 exp 1"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (col_ready !== 1'b0 || m_axi_arvalid !== 1'b0) begin
        errors++; $display("FAIL bp_stall got col_ready=%b arvalid=%b exp 0/0", col_ready, m_axi_arvalid);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (!bp_done && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!bp_done) begin errors++; $display("FAIL bp_resume got second index not accepted exp accepted"); end
    drain();
  endtask

  task automatic test_slow_slave();
    int rd0 = int'(stat_rd_cnt);
    ar_delay = 4; r_delay = 6;
    send(32'd20, 32'h200); send(32'd21, 32'h210); send(32'd22, 32'h220);
    drain();
    checks++;
    if (int'(stat_rd_cnt) - rd0 != 3) begin
      errors++; $display("FAIL slow_rd got=%0d exp=3", int'(stat_rd_cnt) - rd0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      send(32'($urandom_range(0, 3)), $urandom);
    end
    drain();
    checks++;
    if (stat_rd_cnt !== 32'(m_rd) || stat_reuse_cnt !== 32'(m_reuse)) begin
      errors++;
      $display("FAIL random_stats got rd=%0d ru=%0d exp %0d/%0d", stat_rd_cnt, stat_reuse_cnt, m_rd, m_reuse);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    ar_delay = 0; r_delay = 30;
    send(32'd9, 32'h90);
    while (!m_axi_rready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!m_axi_rready) begin errors++; $display("FAIL ar_reset_reach_r got rready=0 exp 1"); end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 ||
        out_xval !== 32'd0 || out_tag !== 32'd0 || m_axi_araddr !== 48'd0 ||
        stat_rd_cnt !== 32'd0 || stat_reuse_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got ov=%b arv=%b rr=%b x=%h t=%h a=%h rd=%0d ru=%0d exp all 0",
               out_valid, m_axi_arvalid, m_axi_rready, out_xval, out_tag, m_axi_araddr,
               stat_rd_cnt, stat_reuse_cnt);
    end
    exp_q.delete(); exp_addr_q.delete();
    m_cv = 1'b0; m_rd = 0; m_reuse = 0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    r_delay = 0;
    send(32'd2, 32'h20);
    drain();
    checks++;
    if (stat_rd_cnt !== 32'd1 || stat_reuse_cnt !== 32'd0) begin
      errors++; $display("FAIL post_reset_stats got rd=%0d ru=%0d exp 1/0", stat_rd_cnt, stat_reuse_cnt);
    end
  endtask

  initial begin
    rstn = 1'b0;
    cfg_base_addr = 48'h1000;
    cfg_flush = 1'b0;
    col_valid = 1'b0;
    col_idx = '0;
    col_tag = '0;
    out_ready = 1'b1;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rdata = '0;
    m_axi_rlast = 1'b1;
    fork
      slave_loop();
      mon_loop();
    join_none
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_miss();
    test_repeat_hit();
    test_flush();
    test_backpressure();
    test_slow_slave();
    test_random();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++; $display("FAIL final_queues got %0d/%0d pending exp 0/0", exp_q.size(), exp_addr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
